// File: rtl/dnn_batch_sequencer.sv
// dnn_batch_sequencer: runs one accuracy pass of the sigmoid/u-law engine over
// NUM_TC test cases. For each case it steps the test-case memory, starts the
// engine, waits for done, argmax-scans the outputs, scores the result against
// the expected label and clears the engine.
// Optional feature macro: DNN_SEQ_TIMEOUT_EN adds a WAIT watchdog of
// TIMEOUT_CYCLES cycles. Without it, WAIT waits forever and timeout_err is 0.
module dnn_batch_sequencer #(
    parameter int NUM_TC         = 5000,
    parameter int CNT_WIDTH      = 16,
    parameter int NUM_OUT        = 10,
    parameter int OUT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        abort,
    output logic                        next_tc,
    output logic                        dnn_start,
    output logic                        dnn_reset,
    input  logic                        dnn_done,
    input  logic signed [OUT_WIDTH-1:0] dnn_out [NUM_OUT],
    input  logic [3:0]                  exp_y,
    output logic                        busy,
    output logic [3:0]                  pred,
    output logic                        pred_valid,
    output logic [CNT_WIDTH-1:0]        hit_count,
    output logic [CNT_WIDTH-1:0]        tc_count,
    output logic                        batch_done,
    output logic                        timeout_err
);

    // Elaboration-time parameter sanity; the 4-bit label limits NUM_OUT to 15.
    if (NUM_OUT < 1 || NUM_OUT > 15) begin : g_bad_num_out
        $error("dnn_batch_sequencer: NUM_OUT must be 1..15");
    end
    if (NUM_TC < 1 || NUM_TC > (2**CNT_WIDTH) - 1) begin : g_bad_num_tc
        $error("dnn_batch_sequencer: NUM_TC out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dnn_batch_sequencer: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_NEXT, S_START, S_WAIT, S_SCAN, S_SCORE, S_CLEAR, S_FIN, S_ABORT
    } state_t;

    localparam logic [3:0]           LAST_IDX  = 4'(NUM_OUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] TC_TARGET = CNT_WIDTH'(NUM_TC);

    state_t                       state_reg;
    logic [3:0]                   idx_reg;
    logic [3:0]                   best_reg;
    logic signed [OUT_WIDTH-1:0]  max_reg;

    // Flatten the engine outputs so the scan can select one by index.
    logic [NUM_OUT-1:0][OUT_WIDTH-1:0] out_flat;
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_flat
        assign out_flat[gi] = dnn_out[gi];
    end

    logic signed [OUT_WIDTH-1:0] cur_val;
    logic                        score_hit;
    assign cur_val   = $signed(out_flat[idx_reg]);
    // A zero prediction never scores, even if the expected label is 0.
    assign score_hit = (best_reg != 4'd0) && (best_reg == exp_y);

`ifdef DNN_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wait_cnt_reg;
`else
    assign timeout_err = 1'b0;
`endif

    // Batch FSM with registered (Moore) outputs: each pulse is set on the edge
    // that enters the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            idx_reg    <= '0;
            best_reg   <= '0;
            max_reg    <= '0;
            next_tc    <= 1'b0;
            dnn_start  <= 1'b0;
            dnn_reset  <= 1'b0;
            busy       <= 1'b0;
            pred       <= '0;
            pred_valid <= 1'b0;
            hit_count  <= '0;
            tc_count   <= '0;
            batch_done <= 1'b0;
`ifdef DNN_SEQ_TIMEOUT_EN
            wait_cnt_reg <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            next_tc    <= 1'b0;
            dnn_start  <= 1'b0;
            dnn_reset  <= 1'b0;
            pred_valid <= 1'b0;
            batch_done <= 1'b0;
            if (abort && state_reg != S_IDLE && state_reg != S_ABORT) begin
                // Abort beats every other transition; counters are frozen.
                state_reg <= S_ABORT;
                dnn_reset <= 1'b1;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (run) begin
                            hit_count <= '0;
                            tc_count  <= '0;
                            pred      <= '0;
`ifdef DNN_SEQ_TIMEOUT_EN
                            timeout_err <= 1'b0;
`endif
                            busy      <= 1'b1;
                            next_tc   <= 1'b1;
                            state_reg <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        dnn_start <= 1'b1;
                        state_reg <= S_START;
                    end
                    S_START: begin
`ifdef DNN_SEQ_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                        state_reg <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (dnn_done) begin
                            idx_reg   <= '0;
                            max_reg   <= '0;
                            best_reg  <= '0;
                            state_reg <= S_SCAN;
                        end
`ifdef DNN_SEQ_TIMEOUT_EN
                        else if (wait_cnt_reg == TO_LAST) begin
                            // Watchdog expiry: score the case as a miss.
                            timeout_err <= 1'b1;
                            pred        <= '0;
                            pred_valid  <= 1'b1;
                            if (tc_count != CNT_MAX) tc_count <= tc_count + 1'b1;
                            dnn_reset   <= 1'b1;
                            state_reg   <= S_CLEAR;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        end
`endif
                    end
                    S_SCAN: begin
                        // Strict compare: ties keep the lower index.
                        if (cur_val > max_reg) begin
                            max_reg  <= cur_val;
                            best_reg <= idx_reg + 4'd1;
                        end
                        if (idx_reg == LAST_IDX) state_reg <= S_SCORE;
                        else                     idx_reg   <= idx_reg + 4'd1;
                    end
                    S_SCORE: begin
                        pred       <= best_reg;
                        pred_valid <= 1'b1;
                        if (tc_count != CNT_MAX) tc_count <= tc_count + 1'b1;
                        if (score_hit && hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
                        dnn_reset  <= 1'b1;
                        state_reg  <= S_CLEAR;
                    end
                    S_CLEAR: begin
                        if (tc_count == TC_TARGET) begin
                            batch_done <= 1'b1;
                            state_reg  <= S_FIN;
                        end else begin
                            next_tc   <= 1'b1;
                            state_reg <= S_NEXT;
                        end
                    end
                    S_FIN, S_ABORT: begin
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dnn_batch_sequencer.sv
// Directed testbench for dnn_batch_sequencer with a small engine model whose
// done latency is programmable (k = lat + 1 WAIT cycles).
module tb_dnn_batch_sequencer;

    localparam int NUM_TC  = 3;
    localparam int CW      = 16;
    localparam int NUM_OUT = 10;
    localparam int OUT_W   = 8;
`ifdef DNN_SEQ_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 65535;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic abort = 1'b0;
    logic next_tc, dnn_start, dnn_reset;
    logic dnn_done = 1'b0;
    logic signed [OUT_W-1:0] dnn_out [NUM_OUT];
    logic [3:0] exp_y = 4'd0;
    logic busy;
    logic [3:0] pred;
    logic pred_valid;
    logic [CW-1:0] hit_count, tc_count;
    logic batch_done, timeout_err;

    int checks = 0;
    int errors = 0;

    dnn_batch_sequencer #(
        .NUM_TC(NUM_TC), .CNT_WIDTH(CW), .NUM_OUT(NUM_OUT),
        .OUT_WIDTH(OUT_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort),
        .next_tc(next_tc), .dnn_start(dnn_start), .dnn_reset(dnn_reset),
        .dnn_done(dnn_done), .dnn_out(dnn_out), .exp_y(exp_y),
        .busy(busy), .pred(pred), .pred_valid(pred_valid),
        .hit_count(hit_count), .tc_count(tc_count),
        .batch_done(batch_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Engine model: done rises lat+1 cycles after the start pulse, cleared by dnn_reset.
    int lat = 20;
    bit never_done = 1'b0;
    int ecnt = 0;
    always @(posedge clk) begin
        if (dnn_reset) begin
            dnn_done <= 1'b0;
            ecnt     <= 0;
        end else if (dnn_start) begin
            if (never_done)    ecnt <= 0;
            else if (lat == 0) dnn_done <= 1'b1;
            else               ecnt <= lat;
        end else if (ecnt > 0) begin
            ecnt <= ecnt - 1;
            if (ecnt == 1) dnn_done <= 1'b1;
        end
    end

    // Pulse monitors.
    int cyc = 0;
    int bd_cnt = 0, pv_cnt = 0, dr_cnt = 0, nt_cnt = 0;
    int nt_time [64];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (batch_done) bd_cnt++;
        if (pred_valid) pv_cnt++;
        if (dnn_reset)  dr_cnt++;
        if (next_tc) begin
            if (nt_cnt < 64) nt_time[nt_cnt] = cyc;
            nt_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // sel: 0 batch_done, 1 dnn_start, 2 dnn_start of case 2, 3 tc_count==1
    task automatic wait_for(input int sel, input int bound, input string tag);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < bound) begin
            step(1);
            n++;
            case (sel)
                0: hit = batch_done;
                1: hit = dnn_start;
                2: hit = dnn_start && (tc_count == 1);
                default: hit = (tc_count == 1);
            endcase
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL %s: wait expired after %0d cycles, required event", tag, n);
        end
    endtask

    task automatic set_peak(input int idx, input int peak, input int rest);
        for (int i = 0; i < NUM_OUT; i++) dnn_out[i] = OUT_W'(rest);
        if (idx >= 0) dnn_out[idx] = OUT_W'(peak);
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step(1);
        run = 1'b0;
    endtask

    int bd0, pv0, nt0, dr0;

    initial begin
        set_peak(-1, 0, 0);
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_busy", busy, 0);
        check("rst_pred", pred, 0);
        check("rst_hit", hit_count, 0);
        check("rst_tc", tc_count, 0);
        check("rst_pulses", {next_tc, dnn_start, dnn_reset, pred_valid, batch_done}, 0);
        check("rst_timeout", timeout_err, 0);

        // Batch 1: peak at index 4 (label 5), k=21 -> 35 cycles per case.
        for (int i = 0; i < NUM_OUT; i++) dnn_out[i] = OUT_W'(i * 3);
        dnn_out[4] = 8'sd100;
        exp_y = 4'd5;
        lat = 20;
        bd0 = bd_cnt; pv0 = pv_cnt; nt0 = nt_cnt;
        pulse_run();
        check("b1_busy_rise", busy, 1);
        check("b1_next_tc_first", next_tc, 1);
        wait_for(0, 400, "b1_batch_done");
        check("b1_hit", hit_count, 3);
        check("b1_tc", tc_count, 3);
        check("b1_pred", pred, 5);
        step(1);
        check("b1_busy_fall", busy, 0);
        check("b1_batch_done_cnt", bd_cnt - bd0, 1);
        check("b1_pred_valid_cnt", pv_cnt - pv0, 3);
        check("b1_next_tc_cnt", nt_cnt - nt0, 3);
        check("b1_period_1", nt_time[nt0 + 1] - nt_time[nt0], 35);
        check("b1_period_2", nt_time[nt0 + 2] - nt_time[nt0 + 1], 35);

        // Batch 2: all outputs -3, expected label 0 -> prediction 0, no hits.
        set_peak(-1, 0, -3);
        exp_y = 4'd0;
        lat = 2;
        pulse_run();
        wait_for(0, 200, "b2_batch_done");
        check("b2_pred", pred, 0);
        check("b2_hit", hit_count, 0);
        check("b2_tc", tc_count, 3);
        step(2);

        // Batch 3: ties at indices 2 and 7 -> label 3; done already high (k=1).
        set_peak(2, 50, 10);
        dnn_out[7] = 8'sd50;
        exp_y = 4'd3;
        lat = 0;
        nt0 = nt_cnt;
        pulse_run();
        wait_for(0, 200, "b3_batch_done");
        check("b3_pred", pred, 3);
        check("b3_hit", hit_count, 3);
        check("b3_period_k1", nt_time[nt0 + 1] - nt_time[nt0], 15);
        step(2);

        // Batch 4: run pulsed mid-batch is ignored.
        set_peak(4, 100, 1);
        exp_y = 4'd5;
        lat = 2;
        bd0 = bd_cnt;
        pulse_run();
        wait_for(3, 200, "b4_first_case");
        pulse_run();
        check("b4_run_ignored_tc", tc_count, 1);
        check("b4_run_ignored_busy", busy, 1);
        wait_for(0, 200, "b4_batch_done");
        check("b4_tc", tc_count, 3);
        check("b4_hit", hit_count, 3);
        check("b4_batch_done_cnt", bd_cnt - bd0, 1);
        step(2);

        // Batch 5: abort during SCAN of case 2.
        bd0 = bd_cnt;
        pulse_run();
        wait_for(2, 200, "b5_case2_start");
        step(6);
        dr0 = dr_cnt;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("b5_abort_reset", dnn_reset, 1);
        check("b5_abort_busy", busy, 1);
        step(1);
        check("b5_idle_busy", busy, 0);
        step(5);
        check("b5_reset_pulses", dr_cnt - dr0, 1);
        check("b5_tc", tc_count, 1);
        check("b5_hit", hit_count, 1);
        check("b5_no_batch_done", bd_cnt - bd0, 0);

`ifdef DNN_SEQ_TIMEOUT_EN
        // Watchdog: engine never finishes; each case times out after 8 WAIT cycles.
        never_done = 1'b1;
        pulse_run();
        wait_for(1, 50, "to_start");
        step(8);
        check("to_not_yet", timeout_err, 0);
        step(1);
        check("to_flag", timeout_err, 1);
        check("to_pred", pred, 0);
        check("to_pred_valid", pred_valid, 1);
        check("to_tc", tc_count, 1);
        wait_for(0, 200, "to_batch_done");
        check("to_tc_final", tc_count, 3);
        check("to_hit", hit_count, 0);
        check("to_sticky", timeout_err, 1);
        step(1);
        pulse_run();
        check("to_cleared_by_run", timeout_err, 0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        step(3);
        never_done = 1'b0;
`endif

        // Reset mid-WAIT of case 2 returns every output to its reset value.
        set_peak(4, 100, 1);
        exp_y = 4'd5;
        lat = 20;
        pulse_run();
        wait_for(2, 200, "r_case2_start");
        step(3);
        check("r_pre_pred", pred, 5);
        check("r_pre_tc", tc_count, 1);
        rst = 1'b1;
        #2;
        check("r_busy", busy, 0);
        check("r_pred", pred, 0);
        check("r_hit", hit_count, 0);
        check("r_tc", tc_count, 0);
        check("r_pulses", {next_tc, dnn_start, dnn_reset, pred_valid, batch_done}, 0);
        step(1);
        rst = 1'b0;
        step(2);
        check("r_stay_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
